// File: rtl/dynamic_segment_register.sv
// Purpose: loadable base register for the relocatable data segment, plus segment+offset address translation.
// Latency: a load is visible on dsr_data_out one edge after the strobe; phys_addr is combinational.
// Backpressure: none; a load strobe is accepted on every edge, and the last strobe wins.
module dynamic_segment_register #(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              SEG_SHIFT   = 0,
  parameter int              OFFSET_W    = 16,
  parameter int              PADDR_W     = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_dsr,
  input  logic [WIDTH-1:0]    dsr_data_in,
  output logic [WIDTH-1:0]    dsr_data_out,
  output logic                dsr_loaded,
  input  logic [OFFSET_W-1:0] addr_offset,
  output logic [PADDR_W-1:0]  phys_addr
);

  // The sum is widened by one bit beyond its widest operand so no carry is
  // lost before the final truncation to PADDR_W bits.
  localparam int SEG_EXT_W = WIDTH + SEG_SHIFT;
  localparam int MAX_AB    = (PADDR_W > SEG_EXT_W) ? PADDR_W : SEG_EXT_W;
  localparam int MAX_ABC   = (MAX_AB > OFFSET_W) ? MAX_AB : OFFSET_W;
  localparam int SUM_W     = MAX_ABC + 1;

  logic [WIDTH-1:0] seg_q;
  logic             loaded_q;

  // Segment register: async clear to RESET_VALUE; a strobe during reset is dropped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      seg_q <= RESET_VALUE;
    end else if (load_dsr) begin
      seg_q <= dsr_data_in;
    end
  end

  // Sticky flag recording that at least one load has happened since reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      loaded_q <= 1'b0;
    end else if (load_dsr) begin
      loaded_q <= 1'b1;
    end
  end

  // The outputs come straight from the flops, with no bypass from dsr_data_in.
  assign dsr_data_out = seg_q;
  assign dsr_loaded   = loaded_q;

  // Both operands are zero-extended, then added; the result wraps modulo 2^PADDR_W.
  assign phys_addr = PADDR_W'((SUM_W'(seg_q) << SEG_SHIFT) + SUM_W'(addr_offset));

endmodule

// File: tb/tb_dynamic_segment_register.sv
module tb_dynamic_segment_register;

  typedef struct {
    logic [15:0] data;
    logic        loaded;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        load_dsr;
  logic [15:0] dsr_data_in;
  logic [15:0] dsr_data_out;
  logic        dsr_loaded;
  logic [15:0] addr_offset;
  logic [15:0] phys_addr;

  int checks;
  int failures;

  exp_t        exp_q[$];
  logic [15:0] phys_q[$];

  // Reference state of the register, kept by the bench.
  logic [15:0] model_reg;
  logic        model_loaded;

  dynamic_segment_register #(
    .WIDTH      (16),
    .RESET_VALUE(16'h0000),
    .SEG_SHIFT  (0),
    .OFFSET_W   (16),
    .PADDR_W    (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_dsr    (load_dsr),
    .dsr_data_in (dsr_data_in),
    .dsr_data_out(dsr_data_out),
    .dsr_loaded  (dsr_loaded),
    .addr_offset (addr_offset),
    .phys_addr   (phys_addr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Record what the register should hold right now.
  task automatic push_state();
    exp_t e;
    e.data   = model_reg;
    e.loaded = model_loaded;
    exp_q.push_back(e);
  endtask

  // Compare the next queued expectation against the DUT.
  task automatic pop_and_check(input string tag);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      check({tag, "_data"}, dsr_data_out, e.data);
      check({tag, "_loaded"}, {15'd0, dsr_loaded}, {15'd0, e.loaded});
    end
  endtask

  // Drive one cycle of stimulus, predict its effect, and check after the edge.
  task automatic drive_edge(input string tag, input logic ld, input logic [15:0] d);
    load_dsr    = ld;
    dsr_data_in = d;
    if (!reset) begin
      model_reg    = 16'h0000;
      model_loaded = 1'b0;
    end else if (ld) begin
      model_reg    = d;
      model_loaded = 1'b1;
    end
    push_state();
    @(posedge clk);
    #1;
    pop_and_check(tag);
  endtask

  // Set a new offset, predict the translated address, and check it.
  task automatic check_phys(input string tag, input logic [15:0] off);
    logic [16:0] full;
    addr_offset = off;
    full = {1'b0, model_reg} + {1'b0, off};
    phys_q.push_back(full[15:0]);
    #1;
    check(tag, phys_addr, phys_q.pop_front());
  endtask

  initial begin
    checks       = 0;
    failures     = 0;
    model_reg    = 16'h0000;
    model_loaded = 1'b0;
    reset        = 1'b0;
    load_dsr     = 1'b1;
    dsr_data_in  = 16'hFFFF;
    addr_offset  = 16'h0000;

    // Reset is held low with an all-ones load pending.
    #2;
    push_state();
    pop_and_check("reset_init");
    drive_edge("reset_edge1", 1'b1, 16'hFFFF);
    drive_edge("reset_edge2", 1'b1, 16'hFFFF);

    // Release reset; the first edge afterwards may load.
    reset = 1'b1;
    drive_edge("single_load", 1'b1, 16'h3000);
    check_phys("xlate_3123", 16'h0123);

    // Reload, then hold for five edges while the data bus changes.
    drive_edge("reload", 1'b1, 16'h5800);
    for (int i = 0; i < 5; i++) begin
      drive_edge($sformatf("hold%0d", i), 1'b0, 16'hAAAA);
    end
    drive_edge("hold_x", 1'b0, 16'hxxxx);

    // Assert reset asynchronously between edges.
    #2;
    reset        = 1'b0;
    model_reg    = 16'h0000;
    model_loaded = 1'b0;
    #1;
    push_state();
    pop_and_check("async_reset");
    check_phys("xlate_in_reset", 16'h0042);

    // Recover, then check that the address wraps modulo 2^16.
    @(negedge clk);
    reset = 1'b1;
    drive_edge("load_f000", 1'b1, 16'hF000);
    check_phys("xlate_wrap", 16'h2000);

    // Back-to-back loads: each edge captures, and the last value wins.
    drive_edge("b2b_1", 1'b1, 16'h1111);
    drive_edge("b2b_2", 1'b1, 16'h2222);
    check_phys("xlate_wrap_ffff", 16'hFFFF);
    drive_edge("b2b_hold", 1'b0, 16'h3333);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dynamic_segment_register.md
# dynamic_segment_register

Loadable segment-base register for the CPU's dynamic (relocatable) data segment. It holds a 16-bit segment value written by the control unit. It also forms the physical address for segmented accesses by combining the held segment with a logical offset. It sits between the control/decode logic, which drives the load strobe and data, and the memory address path, which consumes the segment value and the translated address.

## Interface
Parameters:
- `WIDTH`, 16: width of the segment register and its data ports.
- `RESET_VALUE`, 16'h0000: value loaded on reset.
- `SEG_SHIFT`, 0: left shift applied to the segment value when forming the physical address.
- `OFFSET_W`, 16: width of the logical offset input.
- `PADDR_W`, 16: width of the physical address output.

Ports (clock and reset first):
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: one clock; reset is asynchronous and active-low.
- `load_dsr`, input, 1: load strobe; when high at a rising edge, the register captures `dsr_data_in`.
- `dsr_data_in`, input, WIDTH: new segment value.
- `dsr_data_out`, output, WIDTH: current register contents, driven directly from the flop.
- `dsr_loaded`, output, 1: goes high after the first load since reset.
- `addr_offset`, input, OFFSET_W: logical offset within the segment.
- `phys_addr`, output, PADDR_W: translated address.

## Operation
- Register update rules:
  - While `reset` is low, the register equals RESET_VALUE and `dsr_loaded` is 0, regardless of clock.
  - On a rising edge with `reset` high and `load_dsr` = 1, the register takes `dsr_data_in` and `dsr_loaded` becomes 1.
  - On a rising edge with `reset` high and `load_dsr` = 0, the register and `dsr_loaded` hold their values.
- `dsr_data_out` always reflects the register; there is no combinational bypass from `dsr_data_in`.
- Address translation:
  - `phys_addr` = ((zero-extended `dsr_data_out`) << SEG_SHIFT) + (zero-extended `addr_offset`).
  - The sum is computed at max(PADDR_W, WIDTH+SEG_SHIFT, OFFSET_W)+1 bits, then truncated to the low PADDR_W bits, so it wraps modulo 2^PADDR_W.
  - `phys_addr` is combinational from the register and `addr_offset`.
- Back-to-back loads are allowed. The value present at each edge where `load_dsr` = 1 is captured, and the last one wins.
- X or Z on `dsr_data_in` while `load_dsr` = 0 has no effect.

## Timing
- Load latency: `dsr_data_out` shows the new value immediately after the capturing rising edge (1 cycle from strobe setup).
- Reset assertion:
  - The register clears asynchronously, with no clock needed, including in the middle of a load cycle.
  - `dsr_data_out` and `dsr_loaded` drop within the same delta after `reset` falls.
- Reset deassertion: `reset` is synchronized externally. The first edge after it rises may load.
- Simultaneous reset low and `load_dsr` high: reset wins and the load is discarded.
- `phys_addr` is valid in the same cycle that `addr_offset` or the register changes (combinational path only).

## Test plan
- Reset: hold `reset` = 0 for 2 edges with `load_dsr` = 1 and `dsr_data_in` = 16'hFFFF -> `dsr_data_out` = 16'h0000 and `dsr_loaded` = 0 throughout.
- Single load: release reset, then `load_dsr` = 1 with `dsr_data_in` = 16'h3000 for one edge -> `dsr_data_out` = 16'h3000 after that edge and `dsr_loaded` = 1.
- Reload and hold:
  - `load_dsr` = 1 with 16'h5800 for one edge, then `load_dsr` = 0 with `dsr_data_in` = 16'hAAAA for 5 edges.
  - Expect `dsr_data_out` = 16'h5800 for all 5 edges.
- Async reset mid-operation: with the register at 16'h5800, drop `reset` between edges -> `dsr_data_out` = 16'h0000 immediately, before the next edge.
- Translation:
  - SEG_SHIFT = 0, register = 16'h3000, `addr_offset` = 16'h0123 -> `phys_addr` = 16'h3123.
  - Register = 16'hF000, offset = 16'h2000 -> `phys_addr` = 16'h1000 (wraps).
- Back-to-back loads: load 16'h1111 then 16'h2222 on consecutive edges -> `dsr_data_out` = 16'h1111 after edge 1 and 16'h2222 after edge 2.
